pe_out_router: RTL and testbench

PE_OUT_ROUTER -- requirements
Module: pe_out_router

---
 rtl/pe_out_router_pkg.sv | 26 ++
 rtl/pe_out_router_slot.sv | 54 +++++
 rtl/pe_out_router.sv | 105 ++++++++++
 tb/tb_pe_out_router.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_out_router_pkg.sv
// pe_out_router_pkg -- shared constants for the PE output router.
//   PE_OUT_5x5   : width of the 5x5 switch configuration word
//   SRC_*        : source indices used in each 3-bit destination select
//   SEL_OFF      : canonical "destination disabled" select (5 and 6 also disable)
package pe_out_router_pkg;

  localparam int PE_OUT_5x5 = 15;
  localparam int NUM_SRC    = 5;
  localparam int NUM_DST    = 5;
  localparam int SEL_W      = 3;

  localparam logic [SEL_W-1:0] SRC_ALU = 3'd0;
  localparam logic [SEL_W-1:0] SRC_R0  = 3'd1;
  localparam logic [SEL_W-1:0] SRC_R1  = 3'd2;
  localparam logic [SEL_W-1:0] SRC_R2  = 3'd3;
  localparam logic [SEL_W-1:0] SRC_R3  = 3'd4;
  localparam logic [SEL_W-1:0] SEL_OFF = 3'd7;

  localparam logic [PE_OUT_5x5-1:0] CFG_ALL_OFF = '1;

  // Any select above the last source index disables the destination.
  function automatic logic sel_enabled(input logic [SEL_W-1:0] sel);
    return (sel <= SRC_R3);
  endfunction

endpackage

// File: rtl/pe_out_router_slot.sv
// pe_out_slot -- one destination of the PE output router.
//   sel      : 3-bit source select for this destination (5..7 = disabled)
//   srcs     : all five sources, index 0 = ALU .. 4 = R3
//   issue    : a result beat is being accepted this cycle
//   rdy/vld  : downstream handshake, dout is the registered data
//   ready_ok : this destination can take a new beat (or is disabled)
module pe_out_slot
  import pe_out_router_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [SEL_W-1:0]              sel,
  input  logic [NUM_SRC-1:0][DW-1:0]    srcs,
  input  logic                          issue,
  input  logic                          rdy,
  output logic [DW-1:0]                 dout,
  output logic                          vld,
  output logic                          ready_ok
);

  logic          enabled;
  logic [DW-1:0] sel_data;

  assign enabled  = sel_enabled(sel);
  assign ready_ok = !enabled || !vld || rdy;

  always_comb begin
    sel_data = '0;
    case (sel)
      SRC_ALU: sel_data = srcs[0];
      SRC_R0:  sel_data = srcs[1];
      SRC_R1:  sel_data = srcs[2];
      SRC_R2:  sel_data = srcs[3];
      SRC_R3:  sel_data = srcs[4];
      default: sel_data = '0;
    endcase
  end

  // Reload has priority over drain so a same-edge drain+issue keeps vld high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      vld  <= 1'b0;
    end else if (issue && enabled) begin
      dout <= sel_data;
      vld  <= 1'b1;
    end else if (vld && rdy) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/pe_out_router.sv
// pe_out_router -- routes five PE result sources to five destinations
// (N, S, W, E, LSU) through a reconfigurable 5x5 switch.
//   src_ALU..src_R3     : result sources (indices 0..4)
//   cfg_switch/cfg_load : new configuration and capture request
//   cfg_err             : one-cycle pulse when a cfg_load is rejected
//   in_valid/in_ready   : issue handshake for one result beat
//   dout_X/vld_X/rdy_X  : per-destination registered output handshake
//   stall_cnt           : saturating count of in_valid && !in_ready cycles
module pe_out_router
  import pe_out_router_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DW-1:0]         src_ALU,
  input  logic [DW-1:0]         src_R0,
  input  logic [DW-1:0]         src_R1,
  input  logic [DW-1:0]         src_R2,
  input  logic [DW-1:0]         src_R3,
  input  logic [PE_OUT_5x5-1:0] cfg_switch,
  input  logic                  cfg_load,
  output logic                  cfg_err,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DW-1:0]         dout_N,
  output logic [DW-1:0]         dout_S,
  output logic [DW-1:0]         dout_W,
  output logic [DW-1:0]         dout_E,
  output logic [DW-1:0]         dout_LSU,
  output logic                  vld_N,
  output logic                  vld_S,
  output logic                  vld_W,
  output logic                  vld_E,
  output logic                  vld_LSU,
  input  logic                  rdy_N,
  input  logic                  rdy_S,
  input  logic                  rdy_W,
  input  logic                  rdy_E,
  input  logic                  rdy_LSU,
  output logic [15:0]           stall_cnt
);

  logic [PE_OUT_5x5-1:0]       cfg_r;
  logic [NUM_SRC-1:0][DW-1:0]  srcs;
  logic [DW-1:0]               dout_a [NUM_DST];
  logic [NUM_DST-1:0]          vld_a;
  logic [NUM_DST-1:0]          rdy_a;
  logic [NUM_DST-1:0]          ok_a;
  logic                        issue;
  logic                        cfg_accept;

  assign srcs  = {src_R3, src_R2, src_R1, src_R0, src_ALU};
  assign rdy_a = {rdy_LSU, rdy_E, rdy_W, rdy_S, rdy_N};

  // Disabled slots report ready_ok=1, so an all-off config is always ready.
  assign in_ready   = &ok_a;
  assign issue      = in_valid && in_ready;
  assign cfg_accept = cfg_load && !(|vld_a) && !issue;

  // Slot g takes select field g counted from the MSB: N, S, W, E, LSU.
  for (genvar g = 0; g < NUM_DST; g++) begin : g_slot
    pe_out_slot #(.DW(DW)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .sel      (cfg_r[PE_OUT_5x5-1-SEL_W*g -: SEL_W]),
      .srcs     (srcs),
      .issue    (issue),
      .rdy      (rdy_a[g]),
      .dout     (dout_a[g]),
      .vld      (vld_a[g]),
      .ready_ok (ok_a[g])
    );
  end

  assign dout_N   = dout_a[0];
  assign dout_S   = dout_a[1];
  assign dout_W   = dout_a[2];
  assign dout_E   = dout_a[3];
  assign dout_LSU = dout_a[4];
  assign vld_N    = vld_a[0];
  assign vld_S    = vld_a[1];
  assign vld_W    = vld_a[2];
  assign vld_E    = vld_a[3];
  assign vld_LSU  = vld_a[4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_r   <= CFG_ALL_OFF;
      cfg_err <= 1'b0;
    end else begin
      if (cfg_accept) cfg_r <= cfg_switch;
      cfg_err <= cfg_load && !cfg_accept;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pe_out_router.sv
module tb_pe_out_router;
  import pe_out_router_pkg::*;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] src_v [5];
  logic [14:0]   cfg_switch;
  logic          cfg_load, cfg_err, in_valid, in_ready;
  logic [4:0]    rdy_v;
  logic [DW-1:0] dout_N, dout_S, dout_W, dout_E, dout_LSU;
  logic          vld_N, vld_S, vld_W, vld_E, vld_LSU;
  logic [15:0]   stall_cnt;

  logic [DW-1:0] dout_a [5];
  logic [4:0]    vld_v;
  assign dout_a[0] = dout_N;
  assign dout_a[1] = dout_S;
  assign dout_a[2] = dout_W;
  assign dout_a[3] = dout_E;
  assign dout_a[4] = dout_LSU;
  assign vld_v = {vld_LSU, vld_E, vld_W, vld_S, vld_N};

  pe_out_router #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_ALU(src_v[0]), .src_R0(src_v[1]), .src_R1(src_v[2]),
    .src_R2(src_v[3]), .src_R3(src_v[4]),
    .cfg_switch(cfg_switch), .cfg_load(cfg_load), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready),
    .dout_N(dout_N), .dout_S(dout_S), .dout_W(dout_W), .dout_E(dout_E), .dout_LSU(dout_LSU),
    .vld_N(vld_N), .vld_S(vld_S), .vld_W(vld_W), .vld_E(vld_E), .vld_LSU(vld_LSU),
    .rdy_N(rdy_v[0]), .rdy_S(rdy_v[1]), .rdy_W(rdy_v[2]), .rdy_E(rdy_v[3]), .rdy_LSU(rdy_v[4]),
    .stall_cnt(stall_cnt)
  );

  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] exp_q [5][$];
  logic [14:0]   cfg_model;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every downstream handshake consumes the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 5; i++) begin
        if (vld_v[i] && rdy_v[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat dest%0d: got %0h expected none", i, dout_a[i]);
          end else begin
            chk($sformatf("beat_dest%0d", i), dout_a[i], exp_q[i].pop_front());
          end
        end
      end
    end
  end

  task automatic push_exp();
    logic [2:0] s;
    for (int i = 0; i < 5; i++) begin
      s = cfg_model[14-3*i -: 3];
      if (s <= 3'd4) exp_q[i].push_back(src_v[s]);
    end
  endtask

  task automatic flush_q();
    for (int i = 0; i < 5; i++) exp_q[i].delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic issue(input logic [DW-1:0] a, b, c, d, e);
    int unsigned n = 0;
    src_v[0] = a; src_v[1] = b; src_v[2] = c; src_v[3] = d; src_v[4] = e;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: in_ready got 0 expected 1");
    end else begin
      push_exp();
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load_cfg(input logic [14:0] cfg, input logic expect_err);
    cfg_switch = cfg;
    cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    chk("cfg_err_pulse", cfg_err, expect_err);
    @(posedge clk); #1;
    chk("cfg_err_clear", cfg_err, 1'b0);
    if (!expect_err) cfg_model = cfg;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush_q();
    cfg_model = 15'h7FFF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; cfg_load = 1'b0; cfg_switch = '0; rdy_v = '1;
    for (int i = 0; i < 5; i++) src_v[i] = '0;
    do_reset();
    chk("reset_vld", vld_v, 5'h00);
    chk("reset_dout_N", dout_N, 32'h0);
    chk("reset_stall", stall_cnt, 16'h0);
    chk("reset_cfg_err", cfg_err, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);

    // Basic routing
    load_cfg(15'b000_001_010_011_100, 1'b0);
    issue(32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    chk("route_vld", vld_v, 5'h1F);
    chk("route_N", dout_N, 32'd1);
    chk("route_S", dout_S, 32'd2);
    chk("route_W", dout_W, 32'd3);
    chk("route_E", dout_E, 32'd4);
    chk("route_LSU", dout_LSU, 32'd5);
    @(posedge clk); #1;

    // E stalls the second beat for three cycles
    rdy_v[3] = 1'b0;
    issue(32'd10, 32'd11, 32'd12, 32'd13, 32'd14);
    fork
      issue(32'd20, 32'd21, 32'd22, 32'd23, 32'd24);
      begin
        repeat (3) @(posedge clk); #1;
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_dout_E", dout_E, 32'd13);
        rdy_v[3] = 1'b1;
      end
    join
    chk("stall_cnt3", stall_cnt, 16'd3);
    chk("stall_E_new", dout_E, 32'd23);
    @(posedge clk); #1;

    // Drain and reload on the same edge
    issue(32'd30, 32'd31, 32'd32, 32'd33, 32'd34);
    issue(32'd40, 32'd41, 32'd42, 32'd43, 32'd44);
    chk("reload_vld_N", vld_N, 1'b1);
    chk("reload_dout_N", dout_N, 32'd40);
    @(posedge clk); #1;

    // cfg_load together with an issue: issue uses old config, load rejected
    src_v[0] = 32'd50; src_v[1] = 32'd51; src_v[2] = 32'd52; src_v[3] = 32'd53; src_v[4] = 32'd54;
    in_valid = 1'b1; cfg_load = 1'b1; cfg_switch = 15'h7FFF;
    @(negedge clk);
    chk("cfgissue_ready", in_ready, 1'b1);
    push_exp();
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_load = 1'b0;
    chk("cfgissue_err", cfg_err, 1'b1);
    chk("cfgissue_dout_S", dout_S, 32'd51);
    @(posedge clk); #1;
    chk("cfgissue_err_clear", cfg_err, 1'b0);

    // cfg_load rejected while W holds a beat, accepted after drain
    rdy_v[2] = 1'b0;
    issue(32'd60, 32'd61, 32'd62, 32'd63, 32'd64);
    load_cfg(15'b100_011_010_001_000, 1'b1);
    rdy_v[2] = 1'b1;
    @(posedge clk); #1;
    chk("drained_vld", vld_v, 5'h00);
    issue(32'd65, 32'd66, 32'd67, 32'd68, 32'd69);
    chk("oldcfg_N", dout_N, 32'd65);
    @(posedge clk); #1;
    load_cfg(15'b100_011_010_001_000, 1'b0);
    issue(32'd70, 32'd71, 32'd72, 32'd73, 32'd74);
    chk("newcfg_N", dout_N, 32'd74);
    chk("newcfg_LSU", dout_LSU, 32'd70);
    @(posedge clk); #1;

    // All disabled: accepted and discarded; then saturate stall_cnt
    do_reset();
    issue(32'd80, 32'd81, 32'd82, 32'd83, 32'd84);
    chk("off_vld", vld_v, 5'h00);
    chk("off_dout_N", dout_N, 32'h0);
    load_cfg(15'h0FFF, 1'b0);
    rdy_v[0] = 1'b0;
    issue(32'd90, 32'd91, 32'd92, 32'd93, 32'd94);
    chk("only_N_vld", vld_v, 5'h01);
    in_valid = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    chk("stall_sat", stall_cnt, 16'hFFFF);
    chk("stall_sat_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    rdy_v[0] = 1'b1;
    @(posedge clk); #1;
    chk("sat_drained", vld_v, 5'h00);

    // Asynchronous reset mid-transfer
    load_cfg(15'b000_001_010_011_100, 1'b0);
    rdy_v = '0;
    issue(32'd100, 32'd101, 32'd102, 32'd103, 32'd104);
    chk("pre_reset_vld", vld_v, 5'h1F);
    @(posedge clk); #3;
    rst_n = 1'b0;
    flush_q();
    cfg_model = 15'h7FFF;
    #1;
    chk("async_vld", vld_v, 5'h00);
    chk("async_dout_N", dout_N, 32'h0);
    chk("async_dout_S", dout_S, 32'h0);
    chk("async_dout_W", dout_W, 32'h0);
    chk("async_dout_E", dout_E, 32'h0);
    chk("async_dout_LSU", dout_LSU, 32'h0);
    chk("async_stall", stall_cnt, 16'h0);
    chk("async_cfg_err", cfg_err, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ready", in_ready, 1'b1);
    rdy_v = '1;
    issue(32'd110, 32'd111, 32'd112, 32'd113, 32'd114);
    chk("post_reset_off_vld", vld_v, 5'h00);

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) chk($sformatf("leftover_dest%0d", i), exp_q[i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
